aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Round sequencer for the AES-128 encryption datapath. Accepts one plaintext block, then drives the shared step units (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the round-key source through the initial key addition and 10 rounds; round 10 skips MixColumns. Owns the 128-bit state register and a go/done handshake to every unit, and sits between the top-level stream interface and the step modules.

Parameters:
TIMEOUT_CYC, 64, max cycles to wait for any done/key_valid before flagging error
CNT_W, 7, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  plaintext offered
in_ready  out  1  controller idle, will accept plaintext
in_data  in  128  plaintext block
out_valid  out  1  ciphertext held
out_ready  in  1  consumer accepts ciphertext
out_data  out  128  ciphertext (state register)
op_mat  out  128  operand bus to all step units (state register)
sub_go / shift_go / mix_go / ark_go  out  1 each  one-cycle start pulse to the unit
sub_done / shift_done / mix_done / ark_done  in  1 each  unit result valid
sub_res / shift_res / mix_res / ark_res  in  128 each  unit results
key_req  out  1  one-cycle round-key request pulse
key_idx  out  4  round-key index 0..10
key_valid  in  1  key_in valid
key_in  in  128  round key
rk_mat  out  128  latched round key to AddRoundKey
round_idx  out  4  current round 0..10
busy  out  1  block in flight
err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including in_ready. in_ready rises on the first edge after release.
- States: IDLE, KEY, ARK, SUB, SHIFT, MIX, OUT, ERR. Each step state has a GO cycle followed by a WAIT sub-phase.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into st, set round_idx=0, busy=1, in_ready=0, go to KEY.
- KEY: key_req=1 for one cycle with key_idx=round_idx, then wait. On key_valid, latch key_in into rk_mat and go to ARK.
- Step state X: X_go=1 for exactly one cycle, then wait. On the edge where X_done=1, capture X_res into st and advance. A done in the same cycle as go is ignored; done is sampled only in WAIT.
- Order: KEY→ARK (round 0) → round_idx++ → SUB→SHIFT→MIX→KEY→ARK, repeating. When round_idx==10, MIX is skipped (SHIFT→KEY). After ARK with round_idx==10, go to OUT.
- Phase cost is 1+d cycles, where d≥1 is the response delay. With d=1 everywhere: 51 phases, 102 cycles, and out_valid rises in the cycle after the final capture.
- OUT: out_valid=1 and out_data stable until out_ready. On out_valid&out_ready: busy=0, then IDLE with in_ready=1 on the next cycle. No bubble-free back-to-back operation is required.
- in_valid while busy is ignored; in_data is not sampled.
- Timeout: a counter clears on every GO/req and increments each WAIT cycle. Reaching TIMEOUT_CYC moves to ERR: err=1, all go/req pulses 0, busy=0. ERR returns to IDLE the next cycle. err stays 1 until rst_n; later blocks still process.
- Spurious done/key_valid outside the matching WAIT is ignored.
- Reset mid-operation: immediate return to reset values. A pending unit result is discarded.
- op_mat = st at all times. rk_mat holds the last latched key.

Test Plan:
- FIPS-197 C.1 with behavioural step models (d=1) and key-expansion model: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 103 cycles after the accept edge.
- Pulse audit over one block → exactly 10 sub_go, 10 shift_go, 9 mix_go, 11 ark_go, 11 key_req. key_idx sequence is 0..10. No mix_go while round_idx==10. Every go is 1 cycle wide.
- Random unit delays d=1..20 and out_ready held low 15 cycles → same ciphertext; out_data stable and out_valid high throughout the stall; in_ready=0 until handshake.
- Hold mix_done low in round 3 → err=1 exactly TIMEOUT_CYC (64) wait cycles after mix_go; busy=0; IDLE next cycle. The next block completes correctly and err remains 1.
- Drop rst_n during round 5 SHIFT wait → all outputs 0 asynchronously. After release, in_ready=1 one edge later and a fresh block encrypts correctly.
- in_valid pulsed with different data during busy, plus spurious sub_done in KEY → ignored; ciphertext unchanged.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: holds the cipher state and walks the shared step units and the
// round-key source through the initial key addition and ten rounds.
module aes_round_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] op_mat,
  output logic         sub_go,
  output logic         shift_go,
  output logic         mix_go,
  output logic         ark_go,
  input  logic         sub_done,
  input  logic         shift_done,
  input  logic         mix_done,
  input  logic         ark_done,
  input  logic [127:0] sub_res,
  input  logic [127:0] shift_res,
  input  logic [127:0] mix_res,
  input  logic [127:0] ark_res,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic [127:0] rk_mat,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         err
);

  localparam int               DATA_W     = 128;
  localparam logic [3:0]       LAST_ROUND = 4'd10;
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_ARK, S_SUB, S_SHIFT, S_MIX, S_OUT, S_ERR
  } state_t;

  state_t            state;
  logic              wait_ph;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] st;
  logic              step_done;
  logic [DATA_W-1:0] step_res;

  assign op_mat   = st;
  assign out_data = st;

  // Only the response of the unit owning the current phase is ever looked at.
  always_comb begin
    step_done = 1'b0;
    step_res  = ark_res;
    case (state)
      S_KEY:   begin step_done = key_valid;  step_res = key_in;    end
      S_ARK:   begin step_done = ark_done;   step_res = ark_res;   end
      S_SUB:   begin step_done = sub_done;   step_res = sub_res;   end
      S_SHIFT: begin step_done = shift_done; step_res = shift_res; end
      S_MIX:   begin step_done = mix_done;   step_res = mix_res;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_ph   <= 1'b0;
      tmo_cnt   <= '0;
      st        <= '0;
      rk_mat    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sub_go    <= 1'b0;
      shift_go  <= 1'b0;
      mix_go    <= 1'b0;
      ark_go    <= 1'b0;
      key_req   <= 1'b0;
      key_idx   <= '0;
      round_idx <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sub_go   <= 1'b0;
      shift_go <= 1'b0;
      mix_go   <= 1'b0;
      ark_go   <= 1'b0;
      key_req  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            st        <= in_data;
            round_idx <= '0;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_KEY;
            wait_ph   <= 1'b0;
            key_req   <= 1'b1;
            key_idx   <= '0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_KEY, S_ARK, S_SUB, S_SHIFT, S_MIX: begin
          if (!wait_ph) begin
            wait_ph <= 1'b1;
            tmo_cnt <= '0;
          end else if (step_done) begin
            wait_ph <= 1'b0;
            tmo_cnt <= '0;
            if (state == S_KEY) rk_mat <= step_res;
            else                st     <= step_res;
            case (state)
              S_KEY: begin
                state  <= S_ARK;
                ark_go <= 1'b1;
              end
              S_ARK: begin
                if (round_idx == LAST_ROUND) begin
                  state <= S_OUT;
                end else begin
                  round_idx <= round_idx + 4'd1;
                  state     <= S_SUB;
                  sub_go    <= 1'b1;
                end
              end
              S_SUB: begin
                state    <= S_SHIFT;
                shift_go <= 1'b1;
              end
              S_SHIFT: begin
                // The final round has no MixColumns step.
                if (round_idx == LAST_ROUND) begin
                  state   <= S_KEY;
                  key_req <= 1'b1;
                  key_idx <= round_idx;
                end else begin
                  state  <= S_MIX;
                  mix_go <= 1'b1;
                end
              end
              default: begin
                state   <= S_KEY;
                key_req <= 1'b1;
                key_idx <= round_idx;
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= S_ERR;
            wait_ph <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_ERR: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES step units and key source answer the controller,
// and a scoreboard of model ciphertexts is compared at each output handshake.
module tb_aes_round_ctrl;

  localparam int TIMEOUT_CYC = 64;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data, op_mat, rk_mat, key_in;
  logic         sub_go, shift_go, mix_go, ark_go, key_req, key_valid;
  logic         sub_done, shift_done, mix_done, ark_done;
  logic [127:0] sub_res, shift_res, mix_res, ark_res;
  logic [3:0]   key_idx, round_idx;
  logic         busy, err;

  aes_round_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .op_mat(op_mat),
    .sub_go(sub_go), .shift_go(shift_go), .mix_go(mix_go), .ark_go(ark_go),
    .sub_done(sub_done), .shift_done(shift_done), .mix_done(mix_done), .ark_done(ark_done),
    .sub_res(sub_res), .shift_res(shift_res), .mix_res(mix_res), .ark_res(ark_res),
    .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_in(key_in),
    .rk_mat(rk_mat), .round_idx(round_idx), .busy(busy), .err(err)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, acc_edge = 0, rise_edge = 0;
  int dmax = 1;
  bit drop_mix = 0, spur_en = 0, spur_pend = 0;
  bit pend [5];
  int cnt [5];
  logic [127:0] rsv [5];
  logic [7:0]   sb [256];
  logic [127:0] rk [16];
  logic [31:0]  w [44];
  logic [31:0]  t;
  logic [7:0]   rc;
  logic [127:0] key, pt, got;
  logic [127:0] sb_q [$];
  logic [3:0]   kidx_q [$];
  int n_sub, n_shift, n_mix, n_ark, n_key, n_wide, n_mix10;
  logic [4:0]   prev_go = '0;
  logic [16:0]  ctrl_vec;
  logic [127:0] data_or;

  assign ctrl_vec = {in_ready, out_valid, sub_go, shift_go, mix_go, ark_go, key_req,
                     key_idx, round_idx, busy, err};
  assign data_or  = out_data | op_mat | rk_mat;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c+rw)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
    return shift_rows(sub_bytes(s)) ^ rk[10];
  endfunction

  function automatic int pick();
    return (dmax <= 1) ? 1 : int'($urandom_range(dmax, 1));
  endfunction

  // ---------------- step units and key source ----------------
  initial begin
    sub_done = 0; shift_done = 0; mix_done = 0; ark_done = 0; key_valid = 0;
    sub_res = '0; shift_res = '0; mix_res = '0; ark_res = '0; key_in = '0;
    for (int u = 0; u < 5; u++) begin pend[u] = 0; cnt[u] = 0; rsv[u] = '0; end
    forever begin
      @(negedge clk);
      sub_done = 0; shift_done = 0; mix_done = 0; ark_done = 0; key_valid = 0;
      if (!rst_n) begin
        for (int u = 0; u < 5; u++) pend[u] = 0;
        spur_pend = 0;
      end else begin
        for (int u = 0; u < 5; u++) begin
          if (pend[u]) begin
            cnt[u]--;
            if (cnt[u] == 0) begin
              pend[u] = 0;
              case (u)
                0: begin sub_done = 1;   sub_res = rsv[0];   end
                1: begin shift_done = 1; shift_res = rsv[1]; end
                2: begin mix_done = 1;   mix_res = rsv[2];   end
                3: begin ark_done = 1;   ark_res = rsv[3];   end
                default: begin key_valid = 1; key_in = rsv[4]; end
              endcase
            end
          end
        end
        if (spur_pend) begin
          sub_done = 1;
          sub_res = 128'hdeadbeef_cafef00d_01234567_89abcdef;
          spur_pend = 0;
        end
        if (sub_go)   begin pend[0] = 1; cnt[0] = pick(); rsv[0] = sub_bytes(op_mat);   end
        if (shift_go) begin pend[1] = 1; cnt[1] = pick(); rsv[1] = shift_rows(op_mat);  end
        if (mix_go && !(drop_mix && round_idx == 4'd3)) begin
          pend[2] = 1; cnt[2] = pick(); rsv[2] = mix_columns(op_mat);
        end
        if (ark_go)   begin pend[3] = 1; cnt[3] = pick(); rsv[3] = op_mat ^ rk_mat;     end
        if (key_req) begin
          pend[4] = 1; cnt[4] = pick(); rsv[4] = rk[key_idx];
          spur_pend = spur_en;
        end
      end
    end
  end

  // ---------------- pulse monitor ----------------
  initial forever begin
    @(negedge clk);
    #1;
    if (sub_go)   n_sub++;
    if (shift_go) n_shift++;
    if (mix_go)   n_mix++;
    if (ark_go)   n_ark++;
    if (key_req) begin
      n_key++;
      kidx_q.push_back(key_idx);
    end
    if ((prev_go & {sub_go, shift_go, mix_go, ark_go, key_req}) != 5'b0) n_wide++;
    if (mix_go && round_idx == 4'd10) n_mix10++;
    prev_go = {sub_go, shift_go, mix_go, ark_go, key_req};
  end

  task automatic send(input logic [127:0] p);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1;
    in_data  = p;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", in_ready, 1);
    acc_edge = cyc + 1;
    sb_q.push_back(aes_enc(p));
    @(negedge clk);
    in_valid = 0;
    in_data  = '0;
  endtask

  task automatic recv(input int stall, output logic [127:0] data);
    int n;
    logic [127:0] hold, exp_ct;
    logic ok;
    n  = 0;
    ok = 1;
    @(negedge clk);
    #1;
    while (!out_valid && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("out_valid_seen", out_valid, 1);
    rise_edge = cyc;
    hold = out_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      if (!out_valid || out_data !== hold || in_ready) ok = 0;
    end
    if (stall > 0) chk("stall_hold", ok, 1);
    @(negedge clk);
    out_ready = 1;
    #1;
    exp_ct = '0;
    if (sb_q.size() != 0) exp_ct = sb_q.pop_front();
    data = out_data;
    chk("ciphertext", out_data, exp_ct);
    @(negedge clk);
    out_ready = 0;
    #1;
    chk("busy_clear", busy, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int n, g;
    logic ok;
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] a, inv;
      a   = 8'(x);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    rc  = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) rk[k] = (k < 11) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl_vec, 0);
    chk("reset_data", data_or, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("release_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("release_in_ready_high", in_ready, 1);

    // FIPS-197 C.1 with unit delay 1 and pulse audit
    pt = 128'h00112233445566778899aabbccddeeff;
    n_sub = 0; n_shift = 0; n_mix = 0; n_ark = 0; n_key = 0; n_wide = 0; n_mix10 = 0;
    kidx_q.delete();
    send(pt);
    recv(0, got);
    chk("fips_c1", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("latency", rise_edge - acc_edge, 103);
    chk("n_sub_go", n_sub, 10);
    chk("n_shift_go", n_shift, 10);
    chk("n_mix_go", n_mix, 9);
    chk("n_ark_go", n_ark, 11);
    chk("n_key_req", n_key, 11);
    chk("go_width", n_wide, 0);
    chk("mix_in_round10", n_mix10, 0);
    ok = (kidx_q.size() == 11);
    for (int i = 0; i < kidx_q.size(); i++) if (kidx_q[i] != 4'(i)) ok = 0;
    chk("key_idx_seq", ok, 1);

    // random unit delays plus an output stall
    dmax = 20;
    send(pt);
    recv(15, got);
    chk("stall_c1", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // in_valid while busy and a stray sub_done during KEY
    dmax = 1;
    spur_en = 1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt);
    repeat (20) @(negedge clk);
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = ~pt ^ 128'(i);
      #1;
      if (in_ready || !busy) ok = 0;
    end
    @(negedge clk);
    in_valid = 0;
    in_data  = '0;
    chk("busy_ignores_in", ok, 1);
    recv(0, got);
    spur_en = 0;

    // MixColumns never answers in round 3
    dmax = 3;
    drop_mix = 1;
    send({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    #1;
    while (!(mix_go && round_idx == 4'd3) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    g = cyc;
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("err_set", err, 1);
    chk("err_latency", cyc - g, TIMEOUT_CYC + 1);
    chk("err_busy", busy, 0);
    chk("err_no_pulses", {sub_go, shift_go, mix_go, ark_go, key_req}, 0);
    @(negedge clk);
    #1;
    chk("err_to_idle", in_ready, 1);
    drop_mix = 0;
    if (sb_q.size() != 0) sb_q.delete(0);

    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt);
    recv(2, got);
    chk("err_sticky", err, 1);

    // reset during the round-5 ShiftRows wait
    dmax = 1;
    send({$urandom, $urandom, $urandom, $urandom});
    n = 0;
    #1;
    while (!(shift_go && round_idx == 4'd5) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_ctrl", ctrl_vec, 0);
    chk("midrst_data", data_or, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1;
    #1;
    chk("midrst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_in_ready_high", in_ready, 1);
    pt = 128'h00112233445566778899aabbccddeeff;
    send(pt);
    recv(0, got);
    chk("post_reset_c1", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
